// File: rtl/serializer_rr_arbiter.sv
// Round-robin arbiter feeding one shared parallel-to-serial serializer.
// Grants one word per frame, then waits out the frame and an idle gap.
module serializer_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int LOG2N     = 2,
  parameter int WIDTH     = 32,
  parameter int LOG2WIDTH = 5,
  parameter int GAP       = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]       ser_data_o,
  output logic                   ser_valid_o,
  input  logic                   ser_ready_i,
  output logic [LOG2N-1:0]       grant_id_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam int CW = LOG2WIDTH + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic [LOG2N-1:0] ptr_q, ptr_d;
  logic [LOG2N-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LOG2N-1:0] win;
  logic [LOG2N-1:0] cand;
  logic             found;
  logic             accept;
  int               idx;

  // search starts just past the last winner and wraps
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = LOG2N'(idx);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign accept = (state_q == S_IDLE) && ser_ready_i && found && !reset;

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d  = req_data_i[int'(win)*WIDTH +: WIDTH];
          grant_d = win;
          ptr_d   = win;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = CNT_FULL;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            gap_d   = GAP_LAST;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else gap_d = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= LOG2N'(N_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
    end
  end

  assign ser_data_o   = data_q;
  assign grant_id_o   = grant_q;
  assign ser_valid_o  = (state_q == S_LOAD);
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = (state_q == S_BUSY) && (cnt_q == '0);

endmodule

// File: tb/tb_serializer_rr_arbiter.sv
// Scoreboard bench for serializer_rr_arbiter.
// Timing model: accept T, load T+1, done T+W+2, idle T+W+3+GAP.
module tb_serializer_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int GP = 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] data;
  logic [N-1:0]   valid;
  logic           sr;
  logic [N-1:0]   rdy;
  logic [W-1:0]   sdata;
  logic           svalid;
  logic [1:0]     gid;
  logic           busy;
  logic           fdone;

  logic [N*W-1:0] data1;
  logic [N-1:0]   v1;
  logic           sr1;
  logic [N-1:0]   rdy1;
  logic [W-1:0]   sdata1;
  logic           svalid1;
  logic [1:0]     gid1;
  logic           busy1;
  logic           fdone1;

  serializer_rr_arbiter #(
    .N_REQ(N), .LOG2N(2), .WIDTH(W), .LOG2WIDTH(5), .GAP(GP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_data_i(data), .req_valid_i(valid), .req_ready_o(rdy),
    .ser_data_o(sdata), .ser_valid_o(svalid), .ser_ready_i(sr),
    .grant_id_o(gid), .busy_o(busy), .frame_done_o(fdone)
  );

  serializer_rr_arbiter #(
    .N_REQ(N), .LOG2N(2), .WIDTH(W), .LOG2WIDTH(5), .GAP(0)
  ) dut_g0 (
    .clk(clk), .reset(reset),
    .req_data_i(data1), .req_valid_i(v1), .req_ready_o(rdy1),
    .ser_data_o(sdata1), .ser_valid_o(svalid1), .ser_ready_i(sr1),
    .grant_id_o(gid1), .busy_o(busy1), .frame_done_o(fdone1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // reference model state
  int m_ptr  = N - 1;
  int m_t    = -1000;
  int m_next = 0;
  int n_acc  = 0;
  logic [W+1:0] sb[$];
  int acc_q[$];
  int win_q[$];
  int acc1_q[$];

  logic [N-1:0] er;
  logic [W+1:0] e;
  int  w;
  bit  idle;

  always @(negedge clk) begin
    if (reset) begin
      m_ptr  = N - 1;
      m_t    = -1000;
      m_next = 0;
      sb.delete();
      chk("rst_ready", rdy, 0);
      chk("rst_valid", svalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", fdone, 0);
      chk("rst_grant", gid, 0);
      chk("rst_data", sdata, 0);
    end else begin
      idle = (cyc >= m_next);
      er = '0;
      w = -1;
      if (idle && sr) w = rr_pick(m_ptr, valid);
      if (w >= 0) er[w] = 1'b1;
      chk("ready", rdy, er);
      chk("busy", busy, !idle);
      chk("ser_valid", svalid, cyc == m_t + 1);
      chk("frame_done", fdone, cyc == m_t + W + 2);
      if (svalid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("grant", gid, e[W+1:W]);
          chk("data", sdata, e[W-1:0]);
        end
      end
      if (w >= 0) begin
        sb.push_back({2'(w), data[w*W +: W]});
        m_t    = cyc;
        m_next = cyc + W + 3 + GP;
        m_ptr  = w;
        acc_q.push_back(cyc);
        win_q.push_back(w);
        n_acc++;
      end
    end
    if (!reset && ((rdy1 & v1) != 0)) acc1_q.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int k;
    k = 0;
    while (n_acc < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (n_acc < target) chk("timeout_acc", n_acc, target);
  endtask

  int base, t0, c0;

  initial begin
    valid = '0;
    sr    = 1'b1;
    v1    = '0;
    sr1   = 1'b1;
    for (int k = 0; k < N; k++) begin
      data[k*W +: W]  = 32'h1111_0000 * (k + 1) + 32'h0000_00C3;
      data1[k*W +: W] = 32'h5A00_0000 + k;
    end
    step(3);
    reset = 1'b0;
    step(1);

    // single requester, then drops valid after being taken
    data[2*W +: W] = 32'hA5A5_0F0F;
    valid = 4'b0100;
    base = n_acc;
    wait_acc(base + 1, 20);
    valid = '0;
    chk("t1_grant", win_q[win_q.size()-1], 2);
    step(40);

    // all valid: strict rotation and fixed spacing
    do_reset();
    valid = 4'b1111;
    base = n_acc;
    wait_acc(base + 5, 300);
    valid = '0;
    for (int i = 0; i < 5; i++)
      chk("t2_order", win_q[base + i], i % N);
    for (int i = 1; i < 5; i++)
      chk("t2_space", acc_q[base + i] - acc_q[base + i - 1], 36);
    step(40);

    // pointer at 1, requesters 1 and 3 compete
    do_reset();
    valid = 4'b0010;
    base = n_acc;
    wait_acc(base + 1, 20);
    valid = 4'b1010;
    wait_acc(base + 3, 120);
    valid = '0;
    chk("t3_first", win_q[base + 1], 3);
    chk("t3_second", win_q[base + 2], 1);
    step(40);

    // serializer not ready holds everything off
    do_reset();
    sr = 1'b0;
    valid = 4'b0001;
    step(5);
    base = n_acc;
    sr = 1'b1;
    c0 = cyc;
    wait_acc(base + 1, 10);
    chk("t4_acc_cycle", acc_q[acc_q.size()-1], c0);
    valid = '0;
    step(40);

    // async reset in the middle of a frame
    do_reset();
    valid = 4'b0100;
    base = n_acc;
    wait_acc(base + 1, 20);
    valid = '0;
    t0 = acc_q[acc_q.size()-1];
    while (cyc < t0 + 24) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_valid", svalid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_grant", gid, 0);
    chk("t5_done", fdone, 0);
    step(2);
    valid = 4'b1001;
    reset = 1'b0;
    base = n_acc;
    wait_acc(base + 1, 10);
    chk("t5_winner", win_q[win_q.size()-1], 0);
    valid = '0;
    step(40);

    // zero-gap instance back to back
    do_reset();
    v1 = 4'b0010;
    begin
      int k;
      k = 0;
      while (acc1_q.size() < 3 && k < 200) begin
        @(posedge clk);
        k++;
      end
      #1;
    end
    v1 = '0;
    if (acc1_q.size() < 3) begin
      chk("t6_timeout", acc1_q.size(), 3);
    end else begin
      chk("t6_space1", acc1_q[1] - acc1_q[0], 35);
      chk("t6_space2", acc1_q[2] - acc1_q[1], 35);
      chk("t6_grant", gid1, 1);
    end
    step(40);

    chk("sb_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
